// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider with RISC-V M-extension semantics; DIV_EARLY_OUT_EN enables leading-zero early termination
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   op1_data,
    input  logic [DATA_W-1:0]   op2_data,
    input  logic                start_flag,
    input  logic                annul,
    input  logic                signed_div,
    output logic [2*DATA_W-1:0] div_result,
    output logic                div_ready,
    output logic                div_busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, ZERO, CALC, FIX, DONE} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   dvd, dvd_nx, rem, rem_nx, dsr, dsr_nx;
    logic [DATA_W-1:0]   mag1, mag2, load_dvd;
    logic [DATA_W:0]     shifted, trial;
    logic [CNT_W-1:0]    cnt, cnt_nx, iters;
    logic                sign_q, sign_r, sq_nx, sr_nx, rdy_nx;
    logic [2*DATA_W-1:0] res_nx;
    logic                accept;

    assign mag1    = (signed_div && op1_data[DATA_W-1]) ? -op1_data : op1_data;
    assign mag2    = (signed_div && op2_data[DATA_W-1]) ? -op2_data : op2_data;
    assign accept  = (state == IDLE) && start_flag && !annul;
    assign shifted = {rem, dvd[DATA_W-1]};
    assign trial   = shifted - {1'b0, dsr};
    assign div_busy = (state == ZERO) || (state == CALC) || (state == FIX);

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz;

    // count leading zeros of the dividend magnitude
    always_comb begin
        lz = CNT_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++)
            if (mag1[i]) lz = CNT_W'(DATA_W - 1 - i);
    end

    assign load_dvd = mag1 << lz;

    // iteration count: only the significant dividend bits, at least one
    always_ff @(posedge clk) begin
        if (!rst_n)
            iters <= '0;
        else if (accept)
            iters <= (lz == CNT_W'(DATA_W)) ? CNT_W'(1) : CNT_W'(DATA_W) - lz;
    end
`else
    assign load_dvd = mag1;
    assign iters    = CNT_W'(DATA_W);
`endif

    // state register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            dvd        <= '0;
            rem        <= '0;
            dsr        <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            div_ready  <= 1'b0;
            div_result <= '0;
        end else begin
            state      <= state_nx;
            dvd        <= dvd_nx;
            rem        <= rem_nx;
            dsr        <= dsr_nx;
            cnt        <= cnt_nx;
            sign_q     <= sq_nx;
            sign_r     <= sr_nx;
            div_ready  <= rdy_nx;
            div_result <= res_nx;
        end
    end

    // next state, one quotient bit per CALC cycle, sign fix-up, result hand-off
    always_comb begin
        state_nx = state;
        dvd_nx   = dvd;
        rem_nx   = rem;
        dsr_nx   = dsr;
        cnt_nx   = '0;
        sq_nx    = sign_q;
        sr_nx    = sign_r;
        rdy_nx   = 1'b0;
        res_nx   = '0;
        case (state)
            IDLE: if (accept) begin
                sq_nx  = signed_div & (op1_data[DATA_W-1] ^ op2_data[DATA_W-1]);
                sr_nx  = signed_div & op1_data[DATA_W-1];
                dsr_nx = mag2;
                if (op2_data == '0) begin
                    state_nx = ZERO;
                    rem_nx   = op1_data;
                    dvd_nx   = '0;
                end else begin
                    state_nx = CALC;
                    rem_nx   = '0;
                    dvd_nx   = load_dvd;
                end
            end
            ZERO: begin
                dvd_nx   = '1;
                state_nx = DONE;
            end
            CALC: begin
                rem_nx   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                dvd_nx   = {dvd[DATA_W-2:0], ~trial[DATA_W]};
                cnt_nx   = cnt + CNT_W'(1);
                state_nx = (cnt_nx == iters) ? FIX : CALC;
            end
            FIX: begin
                dvd_nx   = sign_q ? -dvd : dvd;
                rem_nx   = sign_r ? -rem : rem;
                state_nx = DONE;
            end
            DONE: begin
                rdy_nx   = start_flag;
                res_nx   = start_flag ? {rem, dvd} : '0;
                state_nx = start_flag ? DONE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (annul) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            rdy_nx   = 1'b0;
            res_nx   = '0;
        end
    end
endmodule
